fetch_stage: RTL and testbench

Instruction-fetch pipeline stage: owns the program counter, issues single-outstanding requests to instruction memory, and produces the `Instruction`/`PCAddrInc` pair that the decode stage consumes. It sits between instruction memory and the IF/DEC boundary. It honours a hazard-unit `Stall` by holding its outputs and buffering one in-flight response. It honours a branch/jump `Redirect` by flushing and refetching from the new address.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_skid.sv | 28 ++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch interface, skid buffer and stage top.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
   localparam logic [INSTR_W-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [INSTR_W-1:0] pc_inc;
   } skid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus.
// Master is the fetch stage, slave is the memory.
interface fetch_stage_if;
   import fetch_pkg::*;

   logic               IMemReq;
   logic [INSTR_W-1:0] IMemAddr;
   logic               IMemReady;
   logic [INSTR_W-1:0] IMemData;

   modport master (
      output IMemReq,
      output IMemAddr,
      input  IMemReady,
      input  IMemData
   );

   modport slave (
      input  IMemReq,
      input  IMemAddr,
      output IMemReady,
      output IMemData
   );

endinterface

// File: rtl/fetch_skid.sv
// One-entry buffer holding a response that arrived during a stall.
// Load wins over unload; clear empties it.
module fetch_skid
   import fetch_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  logic  unload,
   input  logic  clear,
   input  skid_t din,
   output skid_t dout,
   output logic  valid
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests,
// stall skid buffering and redirect flushing.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [INSTR_W-1:0] ResetAddr = 32'h0000_0000
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Stall,
   input  logic               Redirect,
   input  logic [INSTR_W-1:0] RedirectAddr,
   fetch_stage_if.master      imem,
   output logic [INSTR_W-1:0] Instruction,
   output logic [INSTR_W-1:0] PCAddrInc,
   output logic               InstrValid
);

   fetch_state_t       state;
   logic [INSTR_W-1:0] pc;
   logic [INSTR_W-1:0] pc_inc;
   logic [INSTR_W-1:0] flush_addr;
   logic               pending;
   logic               skid_load;
   logic               skid_unload;
   logic               skid_valid;
   skid_t              skid_in;
   skid_t              skid_out;

   assign pc_inc = pc + PC_INC;
   assign pending = (state != HOLD);

   // A flushed request keeps its old address until memory answers.
   assign imem.IMemReq  = !Reset && pending;
   assign imem.IMemAddr = (state == FLUSH) ? flush_addr : pc;

   assign skid_in = {imem.IMemData, pc_inc};
   assign skid_load = !Redirect && (state == FETCH)
                    && Stall && imem.IMemReady;
   assign skid_unload = !Redirect && (state == HOLD) && !Stall;

   fetch_skid u_skid (
      .clk    (Clock),
      .rst    (Reset),
      .load   (skid_load),
      .unload (skid_unload),
      .clear  (Redirect),
      .din    (skid_in),
      .dout   (skid_out),
      .valid  (skid_valid)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= FETCH;
         pc          <= ResetAddr;
         flush_addr  <= ResetAddr;
         Instruction <= NOP_INSTR;
         PCAddrInc   <= '0;
         InstrValid  <= 1'b0;
      end else if (Redirect) begin
         Instruction <= NOP_INSTR;
         InstrValid  <= 1'b0;
         pc          <= RedirectAddr & ~32'h3;
         if (pending && !imem.IMemReady) begin
            state <= FLUSH;
            if (state == FETCH)
               flush_addr <= pc;
         end else begin
            state <= FETCH;
         end
      end else begin
         unique case (state)
            FETCH: begin
               unique case (1'b1)
                  !Stall && imem.IMemReady: begin
                     Instruction <= imem.IMemData;
                     PCAddrInc   <= pc_inc;
                     InstrValid  <= 1'b1;
                     pc          <= pc_inc;
                  end
                  !Stall && !imem.IMemReady: begin
                     Instruction <= NOP_INSTR;
                     InstrValid  <= 1'b0;
                  end
                  Stall && imem.IMemReady: begin
                     pc    <= pc_inc;
                     state <= HOLD;
                  end
                  default: ;
               endcase
            end
            HOLD: begin
               if (!Stall) begin
                  Instruction <= skid_out.instr;
                  PCAddrInc   <= skid_out.pc_inc;
                  InstrValid  <= skid_valid;
                  state       <= FETCH;
               end
            end
            FLUSH: begin
               if (imem.IMemReady)
                  state <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against an in-order
// delivery model with a variable-latency memory.
module tb_fetch_stage;
   import fetch_pkg::*;

   localparam logic [31:0] K = 32'hA5A5_0000;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] inc;
   } exp_t;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Stall = 1'b0;
   logic        Redirect = 1'b0;
   logic [31:0] RedirectAddr = '0;
   logic [31:0] Instruction, PCAddrInc;
   logic        InstrValid;
   logic [31:0] instr2, inc2;
   logic        valid2;

   fetch_stage_if imem ();
   fetch_stage_if imem2 ();

   always #5 Clock = ~Clock;

   fetch_stage dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .Stall        (Stall),
      .Redirect     (Redirect),
      .RedirectAddr (RedirectAddr),
      .imem         (imem),
      .Instruction  (Instruction),
      .PCAddrInc    (PCAddrInc),
      .InstrValid   (InstrValid)
   );

   fetch_stage #(.ResetAddr(32'hFFFF_FFF8)) dut2 (
      .Clock        (Clock),
      .Reset        (Reset),
      .Stall        (Stall),
      .Redirect     (Redirect),
      .RedirectAddr (RedirectAddr),
      .imem         (imem2),
      .Instruction  (instr2),
      .PCAddrInc    (inc2),
      .InstrValid   (valid2)
   );

   // Zero-wait memory for the wrap-around instance.
   assign imem2.IMemReady = imem2.IMemReq;
   assign imem2.IMemData  = imem2.IMemAddr ^ K;

   exp_t        q[$];
   logic [31:0] mpc;
   bit          flushing;
   int          wcnt;
   int          waits;
   bit          prev_pend;
   logic [31:0] prev_addr;
   logic [31:0] last_instr, last_inc;
   logic        last_valid;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic do_reset();
      @(negedge Clock);
      Reset = 1'b1;
      Stall = 1'b0;
      Redirect = 1'b0;
      RedirectAddr = '0;
      imem.IMemReady = 1'b0;
      imem.IMemData = '0;
      #1;
      n_cmp++;
      if (imem.IMemReq !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_req: got %b want 0", imem.IMemReq);
      end
      repeat (2) @(posedge Clock);
      #1;
      n_cmp++;
      if ({Instruction, PCAddrInc, InstrValid} !== 65'b0) begin
         n_bad++;
         $display("FAIL rst_out: got %h/%h/%b want 0/0/0",
                  Instruction, PCAddrInc, InstrValid);
      end
      q.delete();
      mpc = 32'h0;
      flushing = 0;
      wcnt = 0;
      prev_pend = 0;
      prev_addr = '0;
      last_instr = '0;
      last_inc = '0;
      last_valid = 1'b0;
   endtask

   // One clock: drive inputs and memory, update the model, check.
   task automatic cycle(input bit st, input bit rd,
                        input logic [31:0] tgt);
      bit   acc;
      bit   pend;
      exp_t e;
      @(negedge Clock);
      Reset = 1'b0;
      Stall = st;
      Redirect = rd;
      RedirectAddr = tgt;
      #1;
      if (imem.IMemReq && wcnt >= waits) begin
         imem.IMemReady = 1'b1;
         imem.IMemData = imem.IMemAddr ^ K;
      end else begin
         imem.IMemReady = 1'b0;
         imem.IMemData = $urandom;
      end
      n_cmp++;
      if (imem.IMemReq !== (q.size() == 0)) begin
         n_bad++;
         $display("FAIL req: got %b want %b",
                  imem.IMemReq, q.size() == 0);
      end
      if (prev_pend) begin
         n_cmp++;
         if (imem.IMemAddr !== prev_addr) begin
            n_bad++;
            $display("FAIL addr_stable: got %h want %h",
                     imem.IMemAddr, prev_addr);
         end
      end
      acc = imem.IMemReq && imem.IMemReady;
      if (acc && !rd && !flushing) begin
         n_cmp++;
         if (imem.IMemAddr !== mpc) begin
            n_bad++;
            $display("FAIL fetch_addr: got %h want %h",
                     imem.IMemAddr, mpc);
         end
         e.instr = mpc ^ K;
         e.inc = mpc + 32'd4;
         q.push_back(e);
         mpc = mpc + 32'd4;
      end
      pend = imem.IMemReq && !imem.IMemReady;
      prev_pend = pend;
      prev_addr = imem.IMemAddr;
      wcnt = pend ? wcnt + 1 : 0;
      if (rd) begin
         mpc = tgt & ~32'd3;
         flushing = pend;
         q.delete();
      end else if (acc) begin
         flushing = 0;
      end
      @(posedge Clock);
      #1;
      n_cmp++;
      if (rd) begin
         if (InstrValid !== 1'b0 || Instruction !== 32'h0) begin
            n_bad++;
            $display("FAIL redirect_bubble: got %h/%b want 0/0",
                     Instruction, InstrValid);
         end
      end else if (st) begin
         if (Instruction !== last_instr || PCAddrInc !== last_inc
             || InstrValid !== last_valid) begin
            n_bad++;
            $display("FAIL stall_hold: got %h/%h/%b want %h/%h/%b",
                     Instruction, PCAddrInc, InstrValid,
                     last_instr, last_inc, last_valid);
         end
      end else if (q.size() > 0) begin
         e = q.pop_front();
         if (InstrValid !== 1'b1 || Instruction !== e.instr
             || PCAddrInc !== e.inc) begin
            n_bad++;
            $display("FAIL deliver: got %h/%h/%b want %h/%h/1",
                     Instruction, PCAddrInc, InstrValid,
                     e.instr, e.inc);
         end
      end else begin
         if (InstrValid !== 1'b0 || Instruction !== 32'h0) begin
            n_bad++;
            $display("FAIL bubble: got %h/%b want 0/0",
                     Instruction, InstrValid);
         end
      end
      last_instr = Instruction;
      last_inc = PCAddrInc;
      last_valid = InstrValid;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_zero_wait();
      do_reset();
      waits = 0;
      for (int i = 1; i <= 4; i++) begin
         cycle(0, 0, '0);
         n_cmp++;
         if (PCAddrInc !== 32'(4 * i) || InstrValid !== 1'b1) begin
            n_bad++;
            $display("FAIL zw_inc%0d: got %h/%b want %h/1",
                     i, PCAddrInc, InstrValid, 32'(4 * i));
         end
      end
   endtask

   task automatic test_wait2();
      do_reset();
      waits = 2;
      repeat (10) cycle(0, 0, '0);
   endtask

   task automatic test_stall();
      do_reset();
      waits = 0;
      repeat (2) cycle(0, 0, '0);
      repeat (3) cycle(1, 0, '0);
      repeat (3) cycle(0, 0, '0);
   endtask

   task automatic test_redirect_flush();
      bit seen;
      do_reset();
      waits = 0;
      repeat (8) cycle(0, 0, '0);
      waits = 3;
      cycle(0, 0, '0);
      cycle(0, 1, 32'h0000_0103);
      seen = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
         cycle(0, 0, '0);
         if (InstrValid === 1'b1) begin
            seen = 1;
            n_cmp++;
            if (PCAddrInc !== 32'h104
                || Instruction !== (32'h100 ^ K)) begin
               n_bad++;
               $display("FAIL redir_target: got %h/%h want 104/%h",
                        PCAddrInc, Instruction, 32'h100 ^ K);
            end
         end
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL redir_timeout: got none want valid");
      end
   endtask

   task automatic test_redirect_stall();
      do_reset();
      waits = 0;
      repeat (2) cycle(0, 0, '0);
      cycle(1, 1, 32'h0000_0040);
      cycle(0, 0, '0);
      n_cmp++;
      if (PCAddrInc !== 32'h44 || InstrValid !== 1'b1) begin
         n_bad++;
         $display("FAIL redir_stall: got %h/%b want 44/1",
                  PCAddrInc, InstrValid);
      end
   endtask

   task automatic test_random();
      bit          st, rd;
      logic [31:0] tgt;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         waits = $urandom_range(0, 2);
         st = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 15) == 0);
         tgt = $urandom & 32'h0000_0FFF;
         cycle(st, rd, tgt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      waits = 2;
      repeat (4) cycle(0, 0, '0);
      do_reset();
   endtask

   task automatic test_wrap();
      logic [31:0] a;
      do_reset();
      waits = 0;
      a = 32'hFFFF_FFF8;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, '0);
         n_cmp++;
         if (instr2 !== (a ^ K) || inc2 !== a + 32'd4
             || valid2 !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap%0d: got %h/%h/%b want %h/%h/1",
                     i, instr2, inc2, valid2, a ^ K, a + 32'd4);
         end
         a = a + 32'd4;
      end
   endtask

   initial begin
      imem.IMemReady = 1'b0;
      imem.IMemData = '0;
      waits = 0;
      test_reset();
      test_zero_wait();
      test_wait2();
      test_stall();
      test_redirect_flush();
      test_redirect_stall();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
